// File: rtl/axi_resp_push_pkg.sv
// Shared types and helpers for the completion-to-AXI response push engine.
package axi_resp_push_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPL  = 2'd1,
    CPLD = 2'd2,
    RSV  = 2'd3
  } cpl_type_e;

  typedef enum logic {
    IDLE    = 1'b0,
    R_BURST = 1'b1
  } push_state_e;

  localparam int unsigned DEF_BEAT_DW = 32;
  localparam int unsigned MAX_BEATS   = 1024 / DEF_BEAT_DW;
  localparam int unsigned BEAT_CNT_W  = $clog2(MAX_BEATS) + 1;

  // Length 0 encodes a full 1024-dword completion.
  function automatic logic [10:0] beats_of(input logic [9:0] len,
                                           input int unsigned beat_dw);
    logic [31:0] l;
    l = (len == 10'd0) ? 32'd1024 : {22'd0, len};
    return 11'((l + beat_dw - 32'd1) / beat_dw);
  endfunction

endpackage

// File: rtl/resp_beat_counter.sv
// Loadable down-counter tracking the R beats still owed by the current burst.
module resp_beat_counter
  import axi_resp_push_pkg::*;
#(
  parameter int W = BEAT_CNT_W
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] beats_left,
  output logic         is_last
);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      beats_left <= '0;
    end else if (load) begin
      beats_left <= load_val;
    end else if (dec && (beats_left != '0)) begin
      beats_left <= beats_left - W'(1);
    end
  end

  assign is_last = (beats_left == W'(1));

endmodule

// File: rtl/axi_resp_push_engine.sv
// Pushes P2A completion beats into the AXI B/R response FIFOs with registered writes.
// Optional statistics counters are enabled by defining RESP_PUSH_STATS_EN.
module axi_resp_push_engine
  import axi_resp_push_pkg::*;
#(
  parameter int DATA_W   = 1024,
  parameter int BEAT_DW  = 32,
  parameter int R_DEPTH  = 32,
  parameter int B_W      = 14,
  parameter int R_META_W = 9,
  parameter int AW       = $clog2(R_DEPTH)
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic                       cpl_valid,
  output logic                       cpl_ready,
  input  logic [1:0]                 cpl_type,
  input  logic [9:0]                 cpl_length,
  input  logic [B_W-1:0]             cpl_b_info,
  input  logic [R_META_W-1:0]        cpl_r_info,
  input  logic [DATA_W-1:0]          cpl_data,
  output logic                       b_wr_en,
  output logic [B_W-1:0]             b_wr_data,
  input  logic                       b_full,
  output logic                       r_wr_en,
  output logic [DATA_W+R_META_W:0]   r_wr_data,
  input  logic [AW:0]                r_available,
  output logic                       busy,
  output logic                       err_pulse
`ifdef RESP_PUSH_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [31:0]                stat_b_cnt,
  output logic [31:0]                stat_r_burst_cnt,
  output logic [31:0]                stat_stall_cnt
`endif
);

  localparam int MAX_B = 1024 / BEAT_DW;
  localparam int CNT_W = $clog2(MAX_B) + 1;
  localparam int CW    = AW + 2;

  if (R_DEPTH < MAX_B) begin : g_depth_chk
    $error("R_DEPTH must hold a maximum-length burst");
  end
  if (BEAT_DW * 32 != DATA_W) begin : g_width_chk
    $error("DATA_W must equal BEAT_DW*32");
  end

  // Handshake: a beat moves when cpl_valid && cpl_ready in the same cycle;
  // cpl_ready never depends on cpl_valid, and the FIFO write follows one cycle later.
  push_state_e      state;
  cpl_type_e        ty;
  logic [10:0]      beats;
  logic [CNT_W-1:0] beats_left;
  logic [CNT_W-1:0] load_val;
  logic             is_last;
  logic [CW-1:0]    credit;
  logic             credit_ok;
  logic             xfer;
  logic             hdr_cpl;
  logic             hdr_cpld;
  logic             hdr_bad;
  logic             ld;
  logic             dec;

  assign ty    = cpl_type_e'(cpl_type);
  assign beats = beats_of(cpl_length, BEAT_DW);

  // Space is reserved for the whole burst up front, net of the write already in flight.
  assign credit    = {1'b0, r_available} - CW'(r_wr_en) - CW'(beats_left);
  assign credit_ok = !credit[CW-1] && (32'(credit) >= 32'(beats));

  always_comb begin
    cpl_ready = 1'b1;
    if (state == IDLE) begin
      case (ty)
        CPL:     cpl_ready = !b_full;
        CPLD:    cpl_ready = credit_ok;
        default: cpl_ready = 1'b1;
      endcase
    end
  end

  assign xfer     = cpl_valid && cpl_ready;
  assign hdr_cpl  = xfer && (state == IDLE) && (ty == CPL);
  assign hdr_cpld = xfer && (state == IDLE) && (ty == CPLD);
  assign hdr_bad  = xfer && (state == IDLE) && (ty != CPL) && (ty != CPLD);
  assign ld       = hdr_cpld && (beats > 11'd1);
  assign dec      = xfer && (state == R_BURST);
  assign load_val = CNT_W'(beats - 11'd1);

  resp_beat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .arst       (arst),
    .load       (ld),
    .load_val   (load_val),
    .dec        (dec),
    .beats_left (beats_left),
    .is_last    (is_last)
  );

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      b_wr_en   <= 1'b0;
      b_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      err_pulse <= 1'b0;
    end else begin
      b_wr_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      err_pulse <= 1'b0;
      if (hdr_cpl) begin
        b_wr_en   <= 1'b1;
        b_wr_data <= cpl_b_info;
      end
      if (hdr_cpld) begin
        // The header beat doubles as the first data beat.
        r_wr_en   <= 1'b1;
        r_wr_data <= {cpl_data, cpl_r_info, (beats == 11'd1)};
        if (beats > 11'd1) begin
          state <= R_BURST;
        end
      end
      if (hdr_bad) begin
        err_pulse <= 1'b1;
      end
      if (dec) begin
        r_wr_en   <= 1'b1;
        r_wr_data <= {cpl_data, cpl_r_info, is_last};
        if (is_last) begin
          state <= IDLE;
        end
      end
    end
  end

  assign busy = (state == R_BURST);

`ifdef RESP_PUSH_STATS_EN
  logic stall;
  assign stall = cpl_valid && !cpl_ready;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      stat_b_cnt       <= '0;
      stat_r_burst_cnt <= '0;
      stat_stall_cnt   <= '0;
    end else if (stat_clr) begin
      stat_b_cnt       <= '0;
      stat_r_burst_cnt <= '0;
      stat_stall_cnt   <= '0;
    end else begin
      if (hdr_cpl && (stat_b_cnt != '1)) begin
        stat_b_cnt <= stat_b_cnt + 32'd1;
      end
      if (hdr_cpld && (stat_r_burst_cnt != '1)) begin
        stat_r_burst_cnt <= stat_r_burst_cnt + 32'd1;
      end
      if (stall && (stat_stall_cnt != '1)) begin
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_resp_push_engine.sv
// Directed bench for axi_resp_push_engine (default parameters, 32 dwords per beat).
module tb_axi_resp_push_engine;

  localparam int DATA_W   = 1024;
  localparam int R_META_W = 9;
  localparam int B_W      = 14;
  localparam int AW       = 5;
  localparam int RW       = DATA_W + R_META_W + 1;

  logic                clk;
  logic                arst;
  logic                cpl_valid;
  logic                cpl_ready;
  logic [1:0]          cpl_type;
  logic [9:0]          cpl_length;
  logic [B_W-1:0]      cpl_b_info;
  logic [R_META_W-1:0] cpl_r_info;
  logic [DATA_W-1:0]   cpl_data;
  logic                b_wr_en;
  logic [B_W-1:0]      b_wr_data;
  logic                b_full;
  logic                r_wr_en;
  logic [RW-1:0]       r_wr_data;
  logic [AW:0]         r_available;
  logic                busy;
  logic                err_pulse;
`ifdef RESP_PUSH_STATS_EN
  logic                stat_clr;
  logic [31:0]         stat_b_cnt;
  logic [31:0]         stat_r_burst_cnt;
  logic [31:0]         stat_stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];

  axi_resp_push_engine dut (
    .clk         (clk),
    .arst        (arst),
    .cpl_valid   (cpl_valid),
    .cpl_ready   (cpl_ready),
    .cpl_type    (cpl_type),
    .cpl_length  (cpl_length),
    .cpl_b_info  (cpl_b_info),
    .cpl_r_info  (cpl_r_info),
    .cpl_data    (cpl_data),
    .b_wr_en     (b_wr_en),
    .b_wr_data   (b_wr_data),
    .b_full      (b_full),
    .r_wr_en     (r_wr_en),
    .r_wr_data   (r_wr_data),
    .r_available (r_available),
    .busy        (busy),
    .err_pulse   (err_pulse)
`ifdef RESP_PUSH_STATS_EN
    ,
    .stat_clr         (stat_clr),
    .stat_b_cnt       (stat_b_cnt),
    .stat_r_burst_cnt (stat_r_burst_cnt),
    .stat_stall_cnt   (stat_stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic drive(input logic v, input logic [1:0] t, input logic [9:0] len,
                       input logic [31:0] word, input logic [R_META_W-1:0] meta);
    cpl_valid  = v;
    cpl_type   = t;
    cpl_length = len;
    cpl_data   = {(DATA_W/32){word}};
    cpl_r_info = meta;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_full(input string tag, input logic [RW-1:0] exp);
    n_cmp++;
    assert (r_wr_data === exp) else begin
      n_err++;
      $error("FAIL %s: observed word %0h meta/last %0h expected word %0h meta/last %0h",
             tag, r_wr_data[RW-1 -: 32], r_wr_data[R_META_W:0],
             exp[RW-1 -: 32], exp[R_META_W:0]);
    end
  endtask

  task automatic chk_r(input string tag, input logic [31:0] word,
                       input logic [R_META_W-1:0] meta, input logic last);
    chk({tag, "_en"}, 32'(r_wr_en), 32'd1);
    chk_full(tag, {{(DATA_W/32){word}}, meta, last});
  endtask

  initial begin
    arst = 1'b0;
    b_full = 1'b0;
    r_available = 6'd32;
    cpl_b_info = '0;
`ifdef RESP_PUSH_STATS_EN
    stat_clr = 1'b0;
`endif
    drive(1'b0, 2'd0, 10'd0, 32'd0, 9'd0);
    repeat (3) tick();

    // reset state
    chk("rst_b_en", 32'(b_wr_en), 32'd0);
    chk("rst_b_data", 32'(b_wr_data), 32'd0);
    chk("rst_r_en", 32'(r_wr_en), 32'd0);
    chk_full("rst_r_data", '0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_pulse), 32'd0);
    arst = 1'b1;
    tick();

    // CPL with B FIFO space
    drive(1'b1, 2'd1, 10'd0, 32'd0, 9'd0);
    cpl_b_info = 14'h2A5C;
    #1 chk("cpl_ready", 32'(cpl_ready), 32'd1);
    tick();
    cpl_valid = 1'b0;
    chk("cpl_b_en", 32'(b_wr_en), 32'd1);
    chk("cpl_b_data", 32'(b_wr_data), 32'h2A5C);
    chk("cpl_no_r", 32'(r_wr_en), 32'd0);
    tick();

    // CPL held off by b_full
    b_full = 1'b1;
    drive(1'b1, 2'd1, 10'd0, 32'd0, 9'd0);
    cpl_b_info = 14'h0155;
    #1 chk("bfull_ready", 32'(cpl_ready), 32'd0);
    tick();
    chk("bfull_no_b1", 32'(b_wr_en), 32'd0);
    tick();
    chk("bfull_no_b2", 32'(b_wr_en), 32'd0);
    b_full = 1'b0;
    #1 chk("bfree_ready", 32'(cpl_ready), 32'd1);
    tick();
    cpl_valid = 1'b0;
    chk("bfree_b_en", 32'(b_wr_en), 32'd1);
    chk("bfree_b_data", 32'(b_wr_data), 32'h0155);
    tick();

    // CPLD len=100 -> 4 beats into exactly 4 free entries
    r_available = 6'd4;
    drive(1'b1, 2'd2, 10'd100, 32'hA0A0_0000, 9'h1A3);
    #1 chk("l100_ready", 32'(cpl_ready), 32'd1);
    tick();
    chk_r("l100_b1", 32'hA0A0_0000, 9'h1A3, 1'b0);
    chk("l100_busy", 32'(busy), 32'd1);
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 2'd3, 10'd5, 32'hA0A0_0000 + 32'(i), 9'h1A3);
      #1 chk("l100_burst_ready", 32'(cpl_ready), 32'd1);
      tick();
      chk_r("l100_beat", 32'hA0A0_0000 + 32'(i), 9'h1A3, (i == 3));
    end
    cpl_valid = 1'b0;
    chk("l100_idle", 32'(busy), 32'd0);
    tick();
    chk("l100_done", 32'(r_wr_en), 32'd0);

    // one entry short -> refused; exactly enough -> accepted
    r_available = 6'd3;
    drive(1'b1, 2'd2, 10'd100, 32'h0, 9'h0);
    #1 chk("short_ready", 32'(cpl_ready), 32'd0);
    tick();
    chk("short_no_r", 32'(r_wr_en), 32'd0);
    r_available = 6'd4;
    #1 chk("exact_ready", 32'(cpl_ready), 32'd1);
    cpl_valid = 1'b0;
    tick();

    // single-beat CPLD, then the in-flight write eats the last credit
    r_available = 6'd1;
    drive(1'b1, 2'd2, 10'd32, 32'h5151_5151, 9'h051);
    #1 chk("l32_ready", 32'(cpl_ready), 32'd1);
    tick();
    chk_r("l32_w", 32'h5151_5151, 9'h051, 1'b1);
    chk("l32_idle", 32'(busy), 32'd0);
    drive(1'b1, 2'd2, 10'd32, 32'h5252_5252, 9'h052);
    #1 chk("inflight_ready", 32'(cpl_ready), 32'd0);
    tick();
    chk("inflight_no_r", 32'(r_wr_en), 32'd0);
    #1 chk("inflight_ready2", 32'(cpl_ready), 32'd1);
    tick();
    cpl_valid = 1'b0;
    chk_r("inflight_w", 32'h5252_5252, 9'h052, 1'b1);
    tick();

    // CPLD len=0 -> 32 beats; b_full has no effect mid-burst
    r_available = 6'd32;
    for (int i = 0; i < 32; i++)
      exp_q.push_back({{(DATA_W/32){32'hC000_0000 + 32'(i)}}, 9'h0F0, (i == 31)});
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, (i == 0) ? 2'd2 : 2'd1, 10'd0, 32'hC000_0000 + 32'(i), 9'h0F0);
      b_full = (i != 0);
      #1 chk("l0_ready", 32'(cpl_ready), 32'd1);
      tick();
      chk("l0_en", 32'(r_wr_en), 32'd1);
      chk_full("l0_beat", exp_q.pop_front());
      chk("l0_busy", 32'(busy), (i < 31) ? 32'd1 : 32'd0);
    end
    cpl_valid = 1'b0;
    b_full = 1'b0;
    tick();

    // back-to-back: CPLD(2) -> CPL -> CPLD(1), valid held high
    drive(1'b1, 2'd2, 10'd33, 32'hB0B0_0000, 9'h011);
    #1 chk("b2b_rdy1", 32'(cpl_ready), 32'd1);
    tick();
    chk_r("b2b_w1", 32'hB0B0_0000, 9'h011, 1'b0);
    drive(1'b1, 2'd0, 10'd0, 32'hB0B0_0001, 9'h011);
    #1 chk("b2b_rdy2", 32'(cpl_ready), 32'd1);
    tick();
    chk_r("b2b_w2", 32'hB0B0_0001, 9'h011, 1'b1);
    drive(1'b1, 2'd1, 10'd0, 32'h0, 9'h0);
    cpl_b_info = 14'h3001;
    #1 chk("b2b_rdy3", 32'(cpl_ready), 32'd1);
    tick();
    chk("b2b_b_en", 32'(b_wr_en), 32'd1);
    chk("b2b_b_data", 32'(b_wr_data), 32'h3001);
    chk("b2b_no_r", 32'(r_wr_en), 32'd0);
    drive(1'b1, 2'd2, 10'd1, 32'hC0C0_C0C0, 9'h0C0);
    #1 chk("b2b_rdy4", 32'(cpl_ready), 32'd1);
    tick();
    cpl_valid = 1'b0;
    chk_r("b2b_w4", 32'hC0C0_C0C0, 9'h0C0, 1'b1);
    chk("b2b_no_b", 32'(b_wr_en), 32'd0);
    tick();

    // 3-cycle valid gap mid-burst
    drive(1'b1, 2'd2, 10'd96, 32'hD000_0000, 9'h1D0);
    tick();
    chk_r("gap_w1", 32'hD000_0000, 9'h1D0, 1'b0);
    cpl_valid = 1'b0;
    b_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_no_r", 32'(r_wr_en), 32'd0);
      chk("gap_busy", 32'(busy), 32'd1);
    end
    for (int i = 1; i < 3; i++) begin
      drive(1'b1, 2'd1, 10'd0, 32'hD000_0000 + 32'(i), 9'h1D0);
      #1 chk("gap_ready", 32'(cpl_ready), 32'd1);
      tick();
      chk_r("gap_beat", 32'hD000_0000 + 32'(i), 9'h1D0, (i == 2));
    end
    cpl_valid = 1'b0;
    b_full = 1'b0;
    chk("gap_idle", 32'(busy), 32'd0);
    tick();

    // reset mid-burst abandons the burst
    drive(1'b1, 2'd2, 10'd0, 32'hE000_0000, 9'h0E0);
    tick();
    drive(1'b1, 2'd2, 10'd0, 32'hE000_0001, 9'h0E0);
    tick();
    arst = 1'b0;
    #1;
    chk("mid_rst_r_en", 32'(r_wr_en), 32'd0);
    chk_full("mid_rst_r_data", '0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_b_data", 32'(b_wr_data), 32'd0);
    cpl_valid = 1'b0;
    tick();
    arst = 1'b1;
    tick();
    drive(1'b1, 2'd2, 10'd32, 32'hF1F1_F1F1, 9'h0F1);
    tick();
    cpl_valid = 1'b0;
    chk_r("post_rst_w", 32'hF1F1_F1F1, 9'h0F1, 1'b1);
    chk("post_rst_idle", 32'(busy), 32'd0);
    tick();

    // reserved and NONE types are discarded with an error pulse
    drive(1'b1, 2'd3, 10'd0, 32'h0, 9'h0);
    #1 chk("rsv_ready", 32'(cpl_ready), 32'd1);
    tick();
    cpl_valid = 1'b0;
    chk("rsv_err", 32'(err_pulse), 32'd1);
    chk("rsv_no_r", 32'(r_wr_en), 32'd0);
    chk("rsv_no_b", 32'(b_wr_en), 32'd0);
    tick();
    chk("rsv_err_clr", 32'(err_pulse), 32'd0);
    drive(1'b1, 2'd0, 10'd0, 32'h0, 9'h0);
    tick();
    cpl_valid = 1'b0;
    chk("none_err", 32'(err_pulse), 32'd1);
    chk("none_no_b", 32'(b_wr_en), 32'd0);
    tick();

`ifdef RESP_PUSH_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr_b", stat_b_cnt, 32'd0);
    b_full = 1'b1;
    drive(1'b1, 2'd1, 10'd0, 32'h0, 9'h0);
    repeat (5) tick();
    cpl_valid = 1'b0;
    #1 chk("stat_stall", stat_stall_cnt, 32'd5);
    b_full = 1'b0;
    cpl_valid = 1'b1;
    tick();
    cpl_valid = 1'b0;
    chk("stat_b", stat_b_cnt, 32'd1);
    chk("stat_r_burst", stat_r_burst_cnt, 32'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_resp_push_engine.md
Name: axi_resp_push_engine

Overview:
Next-generation completion-to-AXI response push engine in the TL_TX AXI slave response path. Accepts a beat stream from the P2A completion source. Writes CPL (no data) entries into the B response FIFO and CPLD payloads as multi-beat bursts, with RLAST generated, into the R response FIFO. Improvements over the previous generation:
- beat size, data width and depth are parametrised
- all FIFO writes are registered (glitch-free)
- credit-accurate space reservation
- zero-bubble back-to-back bursts
- illegal-type handling

Parameters:
DATA_W, 1024, payload bits per R beat
BEAT_DW, 32, dwords per R beat (power of 2, BEAT_DW*32 == DATA_W)
R_DEPTH, 32, R FIFO depth; elaboration error if R_DEPTH < 1024/BEAT_DW
B_W, 14, B FIFO entry width
R_META_W, 9, per-beat R sideband (ID, RRESP)
AW, $clog2(R_DEPTH), R FIFO address width

Ports:
clk  in  1  clock
arst  in  1  reset
cpl_valid  in  1  source beat valid
cpl_ready  out  1  beat accepted this cycle (combinational)
cpl_type  in  2  header type: 0 NONE, 1 CPL, 2 CPLD, 3 reserved; sampled only on header beats
cpl_length  in  10  CPLD length in DW, 0 = 1024
cpl_b_info  in  B_W  B entry content
cpl_r_info  in  R_META_W  R sideband
cpl_data  in  DATA_W  beat payload
b_wr_en  out  1  B FIFO write (registered)
b_wr_data  out  B_W  B FIFO data (registered)
b_full  in  1  B FIFO full
r_wr_en  out  1  R FIFO write (registered)
r_wr_data  out  DATA_W+R_META_W+1  {data, meta, last}; last = bit 0 (registered)
r_available  in  AW+1  free R entries
busy  out  1  state == R_BURST
err_pulse  out  1  one-cycle pulse, illegal type discarded (registered)

Behaviour:
Interface: clock clk; reset arst, asynchronous, active-low. Reset value of every registered output and of all internal state is 0; state = IDLE.

Handshake and latency:
- Transfer occurs when cpl_valid && cpl_ready.
- FIFO write appears one cycle after the transfer (latency 1).

Beat count and credit:
- beats = ceil(len/BEAT_DW), with len 0 treated as 1024. Compute in 11 bits.
- credit = r_available - r_wr_en - beats_left, computed in AW+2 bits. This accounts for the in-flight registered write and for beats already reserved.

IDLE:
- CPL: cpl_ready = !b_full. On transfer, next cycle b_wr_en=1 and b_wr_data=cpl_b_info. State stays IDLE.
- CPLD: cpl_ready = (credit >= beats). This reserves the whole burst. On transfer:
  - the header beat is also data beat 1;
  - next cycle r_wr_en=1 with last = (beats==1);
  - if beats>1, beats_left = beats-1 and state goes to R_BURST.
- NONE/reserved: cpl_ready = 1. The beat is discarded, err_pulse fires next cycle, no FIFO write.

R_BURST:
- cpl_ready = 1 (space already reserved); cpl_type and cpl_length are ignored.
- Each transfer decrements beats_left and produces a registered R write.
- last = 1 on the beat where beats_left==1; that transfer returns the state to IDLE.
- cpl_valid low stalls the burst; no write is issued and state holds.

Zero bubble: a header may be accepted in the cycle immediately after the last beat.

Boundaries:
- b_full stalls only CPL; it has no effect during R_BURST.
- r_available == beats exactly: accept.
- A registered write in flight in the same cycle is subtracted before the compare.
- Max burst = 1024/BEAT_DW beats; counter width is $clog2 of that + 1.
- Reset mid-burst: partial burst abandoned, no RLAST emitted. The FIFOs share arst.

Optional Feature:
Macro RESP_PUSH_STATS_EN.
- Defined: adds outputs stat_b_cnt[31:0], stat_r_burst_cnt[31:0] and stat_stall_cnt[31:0].
  - stat_stall_cnt counts cycles with cpl_valid && !cpl_ready.
  - All three counters saturate at max, reset to 0, and clear synchronously on input stat_clr.
- Undefined: these ports and the counters are absent; behaviour is otherwise identical.

Decomposition:
Package axi_resp_push_pkg holds:
- cpl_type_e (NONE/CPL/CPLD/RSV)
- push_state_e (IDLE, R_BURST)
- function beats_of(len, BEAT_DW)
- localparams MAX_BEATS, BEAT_CNT_W

Sub-module resp_beat_counter: loadable down-counter. Outputs beats_left and is_last; its load/decrement is driven by the FSM.

Test Plan:
- CPL header, b_full=0 -> cpl_ready=1, next cycle b_wr_en=1 with b_wr_data=cpl_b_info; with b_full=1 -> cpl_ready=0, no write until b_full drops.
- CPLD len=100, BEAT_DW=32, r_available=4 -> accepted, 4 R writes, last=1 only on 4th; with r_available=3 -> cpl_ready=0.
- CPLD len=0 -> 32 beats, RLAST on beat 32; len=32 -> single beat with last=1, state stays IDLE.
- Back-to-back: CPLD(2 beats) then CPL then CPLD(1 beat), cpl_valid held high -> 4 consecutive accepts, no idle cycle, writes in order.
- cpl_valid deasserted for 3 cycles mid-burst -> r_wr_en low for those 3 cycles, burst resumes, RLAST correct. arst low mid-burst -> all outputs 0, state IDLE.
- cpl_type=3 -> cpl_ready=1, err_pulse=1 next cycle, no FIFO write. With RESP_PUSH_STATS_EN: 5 stall cycles -> stat_stall_cnt=5.
